// File: rtl/csr_sched_tracker_pkg.sv
// Shared sizing constants for the CSR/scheduler handshake tracker.
package csr_sched_tracker_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int PENDING_SIZE = 16;
  localparam int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CNT_W        = $clog2(PENDING_SIZE + 1);

endpackage

// File: rtl/csr_sched_tracker_warp_pending_counter.sv
// Per-warp in-flight instruction counter: up/down, saturating at 0 and PENDING_SIZE.
module warp_pending_counter
  import csr_sched_tracker_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic alm_empty_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PENDING_SIZE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o      = (cnt_q == CNT_MAX);
  assign empty_o     = (cnt_q == '0);
  assign alm_empty_o = (cnt_q <= CNT_W'(1));

  // Simultaneous inc/dec cancel; illegal over/underflow holds the count.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(inc_i && !dec_i && full_o))
        else $warning("warp_pending_counter: issue on a full warp, count held");
      assert (!(dec_i && !inc_i && empty_o))
        else $warning("warp_pending_counter: retire on an empty warp, count held");
    end
  end

endmodule

// File: rtl/csr_sched_tracker.sv
// Scheduler-side CSR responder: per-warp pending counts, CSR lock bits,
// almost-empty query and the free-running cycle counter.
module csr_sched_tracker
  import csr_sched_tracker_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_fire,
  input  logic [NW_WIDTH-1:0]  issue_wid,
  input  logic                 issue_is_csr,
  input  logic                 commit_fire,
  input  logic [NW_WIDTH-1:0]  commit_wid,
  input  logic                 commit_eop,
  input  logic [NW_WIDTH-1:0]  alm_empty_wid,
  output logic                 alm_empty,
  input  logic                 unlock_warp,
  input  logic [NW_WIDTH-1:0]  unlock_wid,
  output logic [NUM_WARPS-1:0] warp_ready,
  output logic [NUM_WARPS-1:0] pending_empty,
  output logic [63:0]          cycles
);

  logic [NUM_WARPS-1:0] lock_q, lock_d;
  logic [NUM_WARPS-1:0] full_w, alm_w;
  logic [63:0]          cycles_q, cycles_d;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic inc, dec;
    assign inc = issue_fire && (issue_wid == NW_WIDTH'(w));
    assign dec = commit_fire && commit_eop && (commit_wid == NW_WIDTH'(w));

    warp_pending_counter u_cnt (
      .clk_i       (clk),
      .rst_ni      (reset),
      .inc_i       (inc),
      .dec_i       (dec),
      .full_o      (full_w[w]),
      .empty_o     (pending_empty[w]),
      .alm_empty_o (alm_w[w])
    );
  end

  // Lock FSM per warp: a CSR issue locks, unlock_warp releases; set wins a collision.
  always_comb begin
    lock_d = lock_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (issue_fire && issue_is_csr && (issue_wid == NW_WIDTH'(w))) begin
        lock_d[w] = 1'b1;
      end else if (unlock_warp && (unlock_wid == NW_WIDTH'(w))) begin
        lock_d[w] = 1'b0;
      end
    end
  end

  assign cycles_d = cycles_q + 64'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q   <= '0;
      cycles_q <= '0;
    end else begin
      lock_q   <= lock_d;
      cycles_q <= cycles_d;
    end
  end

  assign warp_ready = ~lock_q & ~full_w;
  assign alm_empty  = alm_w[alm_empty_wid];
  assign cycles     = cycles_q;

  always @(posedge clk) begin
    if (reset) begin
      assert (!(unlock_warp && !lock_q[unlock_wid]))
        else $warning("csr_sched_tracker: unlock of unlocked warp %0d ignored", unlock_wid);
      assert (!(unlock_warp && issue_fire && issue_is_csr && (issue_wid == unlock_wid)))
        else $warning("csr_sched_tracker: lock set and clear collide on warp %0d", unlock_wid);
    end
  end

endmodule

// File: tb/tb_csr_sched_tracker.sv
// Scoreboard bench for csr_sched_tracker: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_csr_sched_tracker;
  import csr_sched_tracker_pkg::*;

  localparam int S_CYC = 0, S_RDY = 1, S_PE = 2, S_ALM = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_fire, issue_is_csr;
  logic [NW_WIDTH-1:0]  issue_wid;
  logic                 commit_fire, commit_eop;
  logic [NW_WIDTH-1:0]  commit_wid;
  logic [NW_WIDTH-1:0]  alm_empty_wid;
  logic                 alm_empty;
  logic                 unlock_warp;
  logic [NW_WIDTH-1:0]  unlock_wid;
  logic [NUM_WARPS-1:0] warp_ready, pending_empty;
  logic [63:0]          cycles;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  logic [63:0] act;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  csr_sched_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .issue_fire    (issue_fire),
    .issue_wid     (issue_wid),
    .issue_is_csr  (issue_is_csr),
    .commit_fire   (commit_fire),
    .commit_wid    (commit_wid),
    .commit_eop    (commit_eop),
    .alm_empty_wid (alm_empty_wid),
    .alm_empty     (alm_empty),
    .unlock_warp   (unlock_warp),
    .unlock_wid    (unlock_wid),
    .warp_ready    (warp_ready),
    .pending_empty (pending_empty),
    .cycles        (cycles)
  );

  // Monitor: every falling edge, compare all expectations queued since the last one.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.sel)
        S_CYC:   act = cycles;
        S_RDY:   act = {60'd0, warp_ready};
        S_PE:    act = {60'd0, pending_empty};
        default: act = {63'd0, alm_empty};
      endcase
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic want(input string n, input int s, input logic [63:0] e);
    sb.push_back('{n, s, e});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    issue_fire   = 1'b0;
    issue_is_csr = 1'b0;
    commit_fire  = 1'b0;
    commit_eop   = 1'b0;
    unlock_warp  = 1'b0;
  endtask

  task automatic issue(input int w, input logic csr);
    issue_fire = 1'b1; issue_wid = NW_WIDTH'(w); issue_is_csr = csr;
  endtask

  task automatic commit(input int w, input logic eop);
    commit_fire = 1'b1; commit_wid = NW_WIDTH'(w); commit_eop = eop;
  endtask

  task automatic query(input int w);
    alm_empty_wid = NW_WIDTH'(w);
  endtask

  initial begin
    reset = 1'b0;
    issue_fire = 1'b0; issue_is_csr = 1'b0; issue_wid = '0;
    commit_fire = 1'b0; commit_eop = 1'b0; commit_wid = '0;
    unlock_warp = 1'b0; unlock_wid = '0; alm_empty_wid = '0;

    // Outputs while reset is held
    repeat (2) @(posedge clk);
    #1;
    want("rst_cycles", S_CYC, 64'd0);
    want("rst_ready", S_RDY, 64'hF);
    want("rst_pempty", S_PE, 64'hF);
    want("rst_alm0", S_ALM, 64'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Idle 10 cycles, probing alm_empty for each warp along the way
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i < 4) begin
        query(i);
        want($sformatf("idle_alm%0d", i), S_ALM, 64'd1);
      end
    end
    want("idle_cycles10", S_CYC, 64'd10);
    want("idle_ready", S_RDY, 64'hF);
    want("idle_pempty", S_PE, 64'hF);

    // Three plain issues on w2, then retire them
    for (int i = 0; i < 3; i++) begin issue(2, 1'b0); cyc(); end
    query(2);
    want("w2_alm_p3", S_ALM, 64'd0);
    want("w2_pe_p3", S_PE, 64'b1011);
    commit(2, 1'b1); cyc();
    commit(2, 1'b1);
    want("w2_alm_same_cycle_commit", S_ALM, 64'd0);
    cyc();
    want("w2_alm_p1", S_ALM, 64'd1);
    want("w2_pe_p1", S_PE, 64'b1011);
    commit(2, 1'b1); cyc();
    want("w2_pe_p0", S_PE, 64'hF);

    // CSR issue on w1 locks it until unlock_warp
    issue(1, 1'b1); cyc();
    query(1);
    want("w1_locked_ready", S_RDY, 64'b1101);
    want("w1_locked_alm", S_ALM, 64'd1);
    unlock_warp = 1'b1; unlock_wid = NW_WIDTH'(1);
    want("w1_unlock_same_cycle", S_RDY, 64'b1101);
    cyc();
    want("w1_unlocked_ready", S_RDY, 64'hF);
    commit(1, 1'b1); cyc();
    want("w1_drained_pe", S_PE, 64'hF);

    // Fill w0 to PENDING_SIZE
    for (int i = 0; i < PENDING_SIZE; i++) begin issue(0, 1'b0); cyc(); end
    query(0);
    want("w0_full_ready", S_RDY, 64'b1110);
    want("w0_full_alm", S_ALM, 64'd0);
    issue(0, 1'b0); commit(0, 1'b1); cyc();
    want("w0_full_inc_dec", S_RDY, 64'b1110);
    commit(0, 1'b1); cyc();
    want("w0_after_one_commit", S_RDY, 64'hF);
    for (int i = 0; i < PENDING_SIZE - 1; i++) begin commit(0, 1'b1); cyc(); end
    want("w0_drained_pe", S_PE, 64'hF);

    // Two-beat commits on w3: only the eop beat retires
    issue(3, 1'b0); cyc();
    issue(3, 1'b0); cyc();
    query(3);
    want("w3_alm_p2", S_ALM, 64'd0);
    commit(3, 1'b0); cyc();
    want("w3_alm_after_sop", S_ALM, 64'd0);
    commit(3, 1'b1); cyc();
    want("w3_alm_after_eop", S_ALM, 64'd1);
    want("w3_pe_after_eop", S_PE, 64'b0111);
    commit(3, 1'b0); cyc();
    want("w3_pe_after_sop2", S_PE, 64'b0111);
    commit(3, 1'b1); cyc();
    want("w3_pe_drained", S_PE, 64'hF);

    // Protocol errors leave state unchanged
    unlock_warp = 1'b1; unlock_wid = NW_WIDTH'(2); cyc();
    want("unlock_unlocked_ready", S_RDY, 64'hF);
    commit(2, 1'b1); cyc();
    query(2);
    want("dec_at_zero_pe", S_PE, 64'hF);
    want("dec_at_zero_alm", S_ALM, 64'd1);
    issue(2, 1'b0); cyc();
    want("after_underflow_pe", S_PE, 64'b1011);
    want("after_underflow_ready", S_RDY, 64'hF);
    want("after_underflow_alm", S_ALM, 64'd1);
    commit(2, 1'b1); cyc();
    want("after_underflow_drain", S_PE, 64'hF);

    // Reset mid-operation with w1 locked and five in flight
    for (int i = 0; i < 4; i++) begin issue(1, 1'b0); cyc(); end
    issue(1, 1'b1); cyc();
    query(1);
    want("w1_p5_ready", S_RDY, 64'b1101);
    want("w1_p5_pe", S_PE, 64'b1101);
    want("w1_p5_alm", S_ALM, 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    want("midrst_ready", S_RDY, 64'hF);
    want("midrst_pe", S_PE, 64'hF);
    want("midrst_alm", S_ALM, 64'd1);
    want("midrst_cycles", S_CYC, 64'd0);
    cyc();
    reset = 1'b1;
    cyc();
    want("post_rst_cycles1", S_CYC, 64'd1);
    cyc();
    cyc();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
